// File: rtl/mpu_load_unit.sv
// Matrix load stage: streams a row-major FP matrix into the matrix register file,
// one element per clock, then acknowledges (or rejects an out-of-range size).
module mpu_load_unit #(
    parameter int FP              = 32,
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [FP-1:0]              element,
    input  logic [MBITS:0]             matrix_m_size,
    input  logic [NBITS:0]             matrix_n_size,
    input  logic [MATRIX_REG_SIZE-1:0] load_addr,
    output logic                       error,
    output logic                       ack,
    output logic                       write_en,
    output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
    output logic [FP-1:0]              element_out,
    output logic [MBITS:0]             m,
    output logic [NBITS:0]             n,
    output logic [1:0]                 state_dbg
);

    // Handshake: en is a level request sampled only in IDLE; the unit answers with
    // a single-cycle ack (plus error when rejected) and the requester drops en on ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

    state_e                     state_q, state_d;
    logic [MBITS:0]             size_m_q, size_m_d;
    logic [NBITS:0]             size_n_q, size_n_d;
    logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
    logic [FP-1:0]              cap_q, cap_d;
    logic [MBITS:0]             cnt_m_q, cnt_m_d;
    logic [NBITS:0]             cnt_n_q, cnt_n_d;
    logic                       err_q, err_d;

    logic                       error_q, error_d;
    logic                       ack_q, ack_d;
    logic                       wen_q, wen_d;
    logic [MATRIX_REG_SIZE-1:0] rla_q, rla_d;
    logic [FP-1:0]              eout_q, eout_d;
    logic [MBITS:0]             m_q, m_d;
    logic [NBITS:0]             n_q, n_d;

    logic size_ok, last_col, last_row;

    assign size_ok  = (matrix_m_size != '0) && (matrix_m_size <= M_MAX) &&
                      (matrix_n_size != '0) && (matrix_n_size <= N_MAX);
    assign last_col = (cnt_n_q == size_n_q - N_ONE);
    assign last_row = (cnt_m_q == size_m_q - M_ONE);

    // A rejected request also passes through DONE so error/ack land one cycle
    // after the request, exactly like the ack of a successful load.
    always_comb begin
        state_d  = state_q;
        size_m_d = size_m_q;
        size_n_d = size_n_q;
        addr_d   = addr_q;
        cap_d    = cap_q;
        cnt_m_d  = cnt_m_q;
        cnt_n_d  = cnt_n_q;
        err_d    = err_q;
        error_d  = 1'b0;
        ack_d    = 1'b0;
        wen_d    = 1'b0;
        rla_d    = rla_q;
        eout_d   = eout_q;
        m_d      = m_q;
        n_d      = n_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (size_ok) begin
                        size_m_d = matrix_m_size;
                        size_n_d = matrix_n_size;
                        addr_d   = load_addr;
                        cap_d    = element;
                        cnt_m_d  = '0;
                        cnt_n_d  = '0;
                        err_d    = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                wen_d  = 1'b1;
                rla_d  = addr_q;
                eout_d = cap_q;
                m_d    = cnt_m_q;
                n_d    = cnt_n_q;
                if (last_col && last_row) begin
                    state_d = DONE;
                end else begin
                    cap_d = element;
                    if (last_col) begin
                        cnt_n_d = '0;
                        cnt_m_d = cnt_m_q + M_ONE;
                    end else begin
                        cnt_n_d = cnt_n_q + N_ONE;
                    end
                end
            end
            DONE: begin
                ack_d   = 1'b1;
                error_d = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            size_m_q <= '0;
            size_n_q <= '0;
            addr_q   <= '0;
            cap_q    <= '0;
            cnt_m_q  <= '0;
            cnt_n_q  <= '0;
            err_q    <= 1'b0;
            error_q  <= 1'b0;
            ack_q    <= 1'b0;
            wen_q    <= 1'b0;
            rla_q    <= '0;
            eout_q   <= '0;
            m_q      <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            size_m_q <= size_m_d;
            size_n_q <= size_n_d;
            addr_q   <= addr_d;
            cap_q    <= cap_d;
            cnt_m_q  <= cnt_m_d;
            cnt_n_q  <= cnt_n_d;
            err_q    <= err_d;
            error_q  <= error_d;
            ack_q    <= ack_d;
            wen_q    <= wen_d;
            rla_q    <= rla_d;
            eout_q   <= eout_d;
            m_q      <= m_d;
            n_q      <= n_d;
        end
    end

    assign error         = error_q;
    assign ack           = ack_q;
    assign write_en      = wen_q;
    assign reg_load_addr = rla_q;
    assign element_out   = eout_q;
    assign m             = m_q;
    assign n             = n_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mpu_load_unit.sv
// Directed bench for mpu_load_unit: table of load requests with hand-written
// element streams, plus sequences for reset mid-load and back-to-back requests.
module tb_mpu_load_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] element;
    logic [2:0]  matrix_m_size;
    logic [2:0]  matrix_n_size;
    logic [1:0]  load_addr;
    logic        error;
    logic        ack;
    logic        write_en;
    logic [1:0]  reg_load_addr;
    logic [31:0] element_out;
    logic [2:0]  m;
    logic [2:0]  n;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    mpu_load_unit dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .element       (element),
        .matrix_m_size (matrix_m_size),
        .matrix_n_size (matrix_n_size),
        .load_addr     (load_addr),
        .error         (error),
        .ack           (ack),
        .write_en      (write_en),
        .reg_load_addr (reg_load_addr),
        .element_out   (element_out),
        .m             (m),
        .n             (n),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register file model fed by the write port.
    logic [31:0] regs [4][4][4];
    int          wr_cnt = 0;
    initial begin
        for (int a = 0; a < 4; a++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    regs[a][r][c] = 32'h0;
    end
    always @(posedge clk) begin
        if (write_en) begin
            regs[reg_load_addr][m[1:0]][n[1:0]] <= element_out;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct packed {
        logic [2:0]        ms;
        logic [2:0]        ns;
        logic [1:0]        addr;
        logic              exp_err;
        logic [15:0][31:0] el;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        int total;
        total         = int'(v.ms) * int'(v.ns);
        en            = 1'b1;
        matrix_m_size = v.ms;
        matrix_n_size = v.ns;
        load_addr     = v.addr;
        element       = v.el[0];
        tick();
        en = 1'b0;
        chk("cycle0_wen", {31'b0, write_en}, 32'd0);
        if (v.exp_err) begin
            element = 32'hdeadbeef;
            tick();
            chk("err_pulse", {31'b0, error}, 32'd1);
            chk("err_ack", {31'b0, ack}, 32'd1);
            chk("err_no_wen", {31'b0, write_en}, 32'd0);
            tick();
            chk("err_clear", {30'b0, error, ack}, 32'd0);
            return;
        end
        if (total > 1) element = v.el[1];
        for (int k = 1; k <= total; k++) begin
            tick();
            chk("wen", {31'b0, write_en}, 32'd1);
            chk("data", element_out, v.el[k-1]);
            chk("row", {29'b0, m}, 32'((k-1) / int'(v.ns)));
            chk("col", {29'b0, n}, 32'((k-1) % int'(v.ns)));
            chk("addr", {30'b0, reg_load_addr}, {30'b0, v.addr});
            chk("early_ack", {31'b0, ack}, 32'd0);
            if (k + 1 < total) element = v.el[k+1];
            else element = 32'hdeadbeef;
        end
        tick();
        chk("ack", {31'b0, ack}, 32'd1);
        chk("ack_no_err", {31'b0, error}, 32'd0);
        chk("ack_no_wen", {31'b0, write_en}, 32'd0);
        tick();
        chk("ack_single", {31'b0, ack}, 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '0;
        vecs[0].ms = 3'd2; vecs[0].ns = 3'd2; vecs[0].addr = 2'd0;
        vecs[0].el[0] = 32'h3f800000; vecs[0].el[1] = 32'h424951ec;
        vecs[0].el[2] = 32'hc0200000; vecs[0].el[3] = 32'h3e000000;
        vecs[1] = '0;
        vecs[1].ms = 3'd0; vecs[1].ns = 3'd2; vecs[1].exp_err = 1'b1;
        vecs[2] = '0;
        vecs[2].ms = 3'd2; vecs[2].ns = 3'd5; vecs[2].exp_err = 1'b1;
        vecs[3] = '0;
        vecs[3].ms = 3'd1; vecs[3].ns = 3'd1; vecs[3].addr = 2'd2;
        vecs[3].el[0] = 32'h40490fdb;
        vecs[4] = '0;
        vecs[4].ms = 3'd4; vecs[4].ns = 3'd4; vecs[4].addr = 2'd1;
        for (int i = 0; i < 16; i++) vecs[4].el[i] = 32'(i + 1);
        vecs[5] = '0;
        vecs[5].ms = 3'd1; vecs[5].ns = 3'd3; vecs[5].addr = 2'd0;
        vecs[5].el[0] = 32'haaaa0001; vecs[5].el[1] = 32'haaaa0002;
        vecs[5].el[2] = 32'haaaa0003;

        rst = 1'b1; en = 1'b0; element = '0;
        matrix_m_size = '0; matrix_n_size = '0; load_addr = '0;
        repeat (3) tick();
        chk("rst_outputs", {error, ack, write_en, reg_load_addr, m, n}, 32'd0);
        chk("rst_data", element_out, 32'd0);
        chk("rst_state", {30'b0, state_dbg}, 32'd0);
        rst = 1'b0;

        element = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nop_strobes", {29'b0, error, ack, write_en}, 32'd0);
        end
        chk("nop_no_writes", 32'(wr_cnt), 32'd0);

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        chk("reg0_10", regs[0][1][0], 32'hc0200000);
        chk("reg0_11", regs[0][1][1], 32'h3e000000);
        chk("reg0_00", regs[0][0][0], 32'haaaa0001);
        chk("reg0_02", regs[0][0][2], 32'haaaa0003);
        chk("reg2_00", regs[2][0][0], 32'h40490fdb);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk("reg1_intact", regs[1][r][c], 32'(r * 4 + c + 1));

        // Reset in cycle 2 of a 2x2 load to addr 3.
        en = 1'b1; matrix_m_size = 3'd2; matrix_n_size = 3'd2; load_addr = 2'd3;
        element = 32'h11110000;
        tick();
        en = 1'b0; element = 32'h11110001;
        tick();
        chk("rl_w0", element_out, 32'h11110000);
        element = 32'h11110002;
        tick();
        chk("rl_w1_wen", {31'b0, write_en}, 32'd1);
        chk("rl_w1", element_out, 32'h11110001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rl_wen_drop", {31'b0, write_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rl_quiet", {30'b0, ack, write_en}, 32'd0);
        end
        chk("rl_kept00", regs[3][0][0], 32'h11110000);
        chk("rl_kept01", regs[3][0][1], 32'h11110001);
        chk("rl_no10", regs[3][1][0], 32'h0);
        v = '0;
        v.ms = 3'd2; v.ns = 3'd2; v.addr = 2'd3;
        v.el[0] = 32'h22220000; v.el[1] = 32'h22220001;
        v.el[2] = 32'h22220002; v.el[3] = 32'h22220003;
        run_load(v);
        chk("rl_restart11", regs[3][1][1], 32'h22220003);

        // en held through ack; size/addr changes mid-load target the next request.
        en = 1'b1; matrix_m_size = 3'd1; matrix_n_size = 3'd2; load_addr = 2'd2;
        element = 32'h33330000;
        tick();
        matrix_m_size = 3'd3; matrix_n_size = 3'd1; load_addr = 2'd3;
        element = 32'h33330001;
        tick();
        chk("bb_w0", element_out, 32'h33330000);
        chk("bb_w0_addr", {30'b0, reg_load_addr}, 32'd2);
        element = 32'hdeadbeef;
        tick();
        chk("bb_w1", element_out, 32'h33330001);
        chk("bb_w1_idx", {26'b0, m, n}, {26'b0, 3'd0, 3'd1});
        chk("bb_w1_addr", {30'b0, reg_load_addr}, 32'd2);
        tick();
        chk("bb_ack1", {31'b0, ack}, 32'd1);
        element = 32'h44440000;
        tick();
        chk("bb_gap", {30'b0, ack, write_en}, 32'd0);
        en = 1'b0; element = 32'h44440001;
        tick();
        chk("bb2_w0", element_out, 32'h44440000);
        chk("bb2_w0_addr", {30'b0, reg_load_addr}, 32'd3);
        element = 32'h44440002;
        tick();
        chk("bb2_w1_idx", {26'b0, m, n}, {26'b0, 3'd1, 3'd0});
        tick();
        chk("bb2_w2", element_out, 32'h44440002);
        chk("bb2_w2_idx", {26'b0, m, n}, {26'b0, 3'd2, 3'd0});
        tick();
        chk("bb_ack2", {31'b0, ack}, 32'd1);
        tick();
        chk("bb_reg2_01", regs[2][0][1], 32'h33330001);
        chk("bb_reg3_20", regs[3][2][0], 32'h44440002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
